// File: rtl/c64_keyboard_matrix.sv
// rtl/c64_keyboard_matrix.sv - PS/2 set-2 scancodes to C64 8x8 key matrix and CIA #1 port inputs
//
// Decodes PS/2 set-2 bytes into an 8x8 key matrix (key[col][row]) plus a
// separate RESTORE line. It then resolves the matrix against the CIA #1 port
// drives in both directions and merges the joysticks into the port inputs.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   kb_data, kb_valid   scancode byte and its one-cycle strobe
//   pa_out, pb_out      CIA #1 column / row drive, active-low
//   joy_a_n, joy_b_n    joysticks {fire,right,left,down,up}, active-low
//   pa_in, pb_in        registered values presented to CIA #1 port A / B
//   restore_n           RESTORE key, active-low
//   key_event           one-cycle pulse per accepted matrix make/break

module c64_keyboard_matrix #(
  parameter bit JOY_SWAP   = 1'b0,
  parameter bit CLR_ON_BAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kb_data,
  input  logic       kb_valid,
  input  logic [7:0] pa_out,
  input  logic [7:0] pb_out,
  input  logic [4:0] joy_a_n,
  input  logic [4:0] joy_b_n,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       restore_n,
  output logic       key_event
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_PAUSE
  } state_t;

  state_t          state;
  logic [2:0]      skip;
  logic [7:0][7:0] key;   // key[col][row], 1 = pressed

  // Table entry format: {hit, restore, col[2:0], row[2:0]}
  function automatic logic [7:0] k(input logic [2:0] c, input logic [2:0] r);
    return {2'b10, c, r};
  endfunction

  function automatic logic [7:0] lookup(input logic ext, input logic [7:0] code);
    logic [7:0] res;
    res = 8'h00;
    case ({ext, code})
      // column 0: DEL RETURN CRSR-RT F7 F1 F3 F5 CRSR-DN
      9'h066: res = k(3'd0, 3'd0);
      9'h05A: res = k(3'd0, 3'd1);
      9'h083: res = k(3'd0, 3'd3);
      9'h005: res = k(3'd0, 3'd4);
      9'h004: res = k(3'd0, 3'd5);
      9'h003: res = k(3'd0, 3'd6);
      // column 1: 3 W A 4 Z S E LSHIFT
      9'h026: res = k(3'd1, 3'd0);
      9'h01D: res = k(3'd1, 3'd1);
      9'h01C: res = k(3'd1, 3'd2);
      9'h025: res = k(3'd1, 3'd3);
      9'h01A: res = k(3'd1, 3'd4);
      9'h01B: res = k(3'd1, 3'd5);
      9'h024: res = k(3'd1, 3'd6);
      9'h012: res = k(3'd1, 3'd7);
      // column 2: 5 R D 6 C F T X
      9'h02E: res = k(3'd2, 3'd0);
      9'h02D: res = k(3'd2, 3'd1);
      9'h023: res = k(3'd2, 3'd2);
      9'h036: res = k(3'd2, 3'd3);
      9'h021: res = k(3'd2, 3'd4);
      9'h02B: res = k(3'd2, 3'd5);
      9'h02C: res = k(3'd2, 3'd6);
      9'h022: res = k(3'd2, 3'd7);
      // column 3: 7 Y G 8 B H U V
      9'h03D: res = k(3'd3, 3'd0);
      9'h035: res = k(3'd3, 3'd1);
      9'h034: res = k(3'd3, 3'd2);
      9'h03E: res = k(3'd3, 3'd3);
      9'h032: res = k(3'd3, 3'd4);
      9'h033: res = k(3'd3, 3'd5);
      9'h03C: res = k(3'd3, 3'd6);
      9'h02A: res = k(3'd3, 3'd7);
      // column 4: 9 I J 0 M K O N
      9'h046: res = k(3'd4, 3'd0);
      9'h043: res = k(3'd4, 3'd1);
      9'h03B: res = k(3'd4, 3'd2);
      9'h045: res = k(3'd4, 3'd3);
      9'h03A: res = k(3'd4, 3'd4);
      9'h042: res = k(3'd4, 3'd5);
      9'h044: res = k(3'd4, 3'd6);
      9'h031: res = k(3'd4, 3'd7);
      // column 5: + P L - . : @ ,
      9'h079: res = k(3'd5, 3'd0);
      9'h04D: res = k(3'd5, 3'd1);
      9'h04B: res = k(3'd5, 3'd2);
      9'h04E: res = k(3'd5, 3'd3);
      9'h049: res = k(3'd5, 3'd4);
      9'h04C: res = k(3'd5, 3'd5);
      9'h054: res = k(3'd5, 3'd6);
      9'h041: res = k(3'd5, 3'd7);
      // column 6: pound * ; HOME RSHIFT = / (up-arrow unmapped)
      9'h05D: res = k(3'd6, 3'd0);
      9'h05B: res = k(3'd6, 3'd1);
      9'h052: res = k(3'd6, 3'd2);
      9'h059: res = k(3'd6, 3'd4);
      9'h055: res = k(3'd6, 3'd5);
      9'h04A: res = k(3'd6, 3'd7);
      // column 7: 1 <- CTRL 2 SPACE C= Q RUN/STOP
      9'h016: res = k(3'd7, 3'd0);
      9'h00E: res = k(3'd7, 3'd1);
      9'h00D: res = k(3'd7, 3'd2);
      9'h01E: res = k(3'd7, 3'd3);
      9'h029: res = k(3'd7, 3'd4);
      9'h014: res = k(3'd7, 3'd5);
      9'h015: res = k(3'd7, 3'd6);
      9'h076: res = k(3'd7, 3'd7);
      // E0-prefixed: keypad enter, cursor keys, delete, home, PgUp=RESTORE
      9'h15A: res = k(3'd0, 3'd1);
      9'h174: res = k(3'd0, 3'd2);
      9'h172: res = k(3'd0, 3'd7);
      9'h171: res = k(3'd0, 3'd0);
      9'h16C: res = k(3'd6, 3'd3);
      9'h17D: res = 8'b0100_0000;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  logic       do_lookup;
  logic       lk_ext;
  logic       lk_brk;
  logic       is_bat;
  logic [7:0] lk;

  // Decide, for the byte on kb_data, whether it completes a key sequence.
  always_comb begin
    do_lookup = 1'b0;
    lk_ext    = 1'b0;
    lk_brk    = 1'b0;
    is_bat    = kb_valid && (state == S_IDLE) && (kb_data == 8'hAA) && CLR_ON_BAT;
    if (kb_valid) begin
      case (state)
        S_IDLE: begin
          if (kb_data != 8'hE0 && kb_data != 8'hF0 && kb_data != 8'hE1 && !is_bat)
            do_lookup = 1'b1;
        end
        S_EXT: begin
          // E0 12 / E0 59 are the fake shifts some keyboards wrap around
          // navigation keys; they must not touch the real shift keys.
          if (kb_data != 8'hF0 && kb_data != 8'h12 && kb_data != 8'h59) begin
            do_lookup = 1'b1;
            lk_ext    = 1'b1;
          end
        end
        S_BRK: begin
          do_lookup = 1'b1;
          lk_brk    = 1'b1;
        end
        S_EXTBRK: begin
          do_lookup = 1'b1;
          lk_ext    = 1'b1;
          lk_brk    = 1'b1;
        end
        default: ;
      endcase
    end
    lk = lookup(lk_ext, kb_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      skip      <= 3'd0;
      key       <= '0;
      restore_n <= 1'b1;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (kb_valid) begin
        case (state)
          S_IDLE: begin
            if (kb_data == 8'hE0) state <= S_EXT;
            else if (kb_data == 8'hF0) state <= S_BRK;
            else if (kb_data == 8'hE1) begin
              state <= S_PAUSE;
              skip  <= 3'd7;
            end
          end
          S_EXT:            state <= (kb_data == 8'hF0) ? S_EXTBRK : S_IDLE;
          S_BRK, S_EXTBRK:  state <= S_IDLE;
          S_PAUSE: begin
            // Pause/Break sends E1 plus seven bytes with no break code.
            skip <= skip - 3'd1;
            if (skip <= 3'd1) state <= S_IDLE;
          end
          default:          state <= S_IDLE;
        endcase
      end

      if (is_bat) begin
        key       <= '0;
        restore_n <= 1'b1;
      end else if (do_lookup && lk[7]) begin
        // Redundant make/break still pulses key_event.
        key[lk[5:3]][lk[2:0]] <= ~lk_brk;
        key_event             <= 1'b1;
      end else if (do_lookup && lk[6]) begin
        restore_n <= lk_brk;
      end
    end
  end

  logic [7:0] ja;
  logic [7:0] jb;
  logic [7:0] pa_hit;
  logic [7:0] pb_hit;

  // Direct column-to-row resolution only; multi-key ghost paths are ignored.
  always_comb begin
    ja     = {3'b111, (JOY_SWAP ? joy_b_n : joy_a_n)};
    jb     = {3'b111, (JOY_SWAP ? joy_a_n : joy_b_n)};
    pa_hit = '0;
    pb_hit = '0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        pb_hit[r] = pb_hit[r] | (key[c][r] & ~pa_out[c]);
        pa_hit[c] = pa_hit[c] | (key[c][r] & ~pb_out[r]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pa_in <= 8'hFF;
      pb_in <= 8'hFF;
    end else begin
      pa_in <= ~pa_hit & ja;
      pb_in <= ~pb_hit & jb;
    end
  end

endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// tb/tb_c64_keyboard_matrix.sv - self-checking bench for c64_keyboard_matrix

module tb_c64_keyboard_matrix;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] kb_data;
  logic       kb_valid;
  logic [7:0] pa_out;
  logic [7:0] pb_out;
  logic [4:0] joy_a_n;
  logic [4:0] joy_b_n;
  logic [7:0] pa_in;
  logic [7:0] pb_in;
  logic       restore_n;
  logic       key_event;

  int tests = 0;
  int fails = 0;
  int ev_cnt = 0;

  always #5 clk = ~clk;

  c64_keyboard_matrix dut (
    .clk(clk), .reset(reset), .kb_data(kb_data), .kb_valid(kb_valid),
    .pa_out(pa_out), .pb_out(pb_out), .joy_a_n(joy_a_n), .joy_b_n(joy_b_n),
    .pa_in(pa_in), .pb_in(pb_in), .restore_n(restore_n), .key_event(key_event)
  );

  // Count key_event pulses just after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (key_event === 1'b1) ev_cnt++;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    kb_data  = b;
    kb_valid = 1'b1;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    kb_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  bit         m_key [8][8];
  bit         m_rst_n;
  logic [7:0] seq [$];

  function automatic void m_clear();
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) m_key[c][r] = 1'b0;
    m_rst_n = 1'b1;
    seq.delete();
  endfunction

  // Subset of the key table covering every code the random stimulus uses.
  function automatic void bench_map(input bit ext, input logic [7:0] code,
                                    output bit hit, output bit rst, output int col, output int row);
    hit = 1'b1; rst = 1'b0; col = 0; row = 0;
    case ({ext, code})
      9'h01C: begin col = 1; row = 2; end
      9'h029: begin col = 7; row = 4; end
      9'h05A: begin col = 0; row = 1; end
      9'h012: begin col = 1; row = 7; end
      9'h059: begin col = 6; row = 4; end
      9'h076: begin col = 7; row = 7; end
      9'h016: begin col = 7; row = 0; end
      9'h01B: begin col = 1; row = 5; end
      9'h023: begin col = 2; row = 2; end
      9'h15A: begin col = 0; row = 1; end
      9'h174: begin col = 0; row = 2; end
      9'h17D: begin hit = 1'b0; rst = 1'b1; end
      default: hit = 1'b0;
    endcase
  endfunction

  // Collects bytes until they form a complete key sequence, then applies it.
  function automatic void model_byte(input logic [7:0] b, output bit ev);
    bit ext, brk, hit, rst;
    int col, row;
    ev = 1'b0;
    seq.push_back(b);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) seq.delete();
      return;
    end
    if (seq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) return;
    if (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0) return;
    ext = (seq[0] == 8'hE0);
    brk = (seq.size() >= 2) && (seq[seq.size()-2] == 8'hF0);
    seq.delete();
    if (!ext && !brk && b == 8'hAA) begin
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 8; r++) m_key[c][r] = 1'b0;
      m_rst_n = 1'b1;
      return;
    end
    if (ext && !brk && (b == 8'h12 || b == 8'h59)) return;
    bench_map(ext, b, hit, rst, col, row);
    if (hit) begin
      m_key[col][row] = !brk;
      ev = 1'b1;
    end else if (rst) begin
      m_rst_n = brk;
    end
  endfunction

  function automatic logic [7:0] m_pb(input logic [7:0] pa_o, input logic [4:0] jb5);
    logic [7:0] v;
    v = {3'b111, jb5};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (m_key[c][r] && !pa_o[c]) v[r] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] m_pa(input logic [7:0] pb_o, input logic [4:0] ja5);
    logic [7:0] v;
    v = {3'b111, ja5};
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (m_key[c][r] && !pb_o[r]) v[c] = 1'b0;
    return v;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    string      name;
    int         n;
    logic [7:0] b0, b1, b2;
    logic [7:0] pa_o, pb_o;
    logic [4:0] ja, jb;
    logic [7:0] e_pa, e_pb;
    logic       e_rst;
    int         e_ev;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [7:0] bytes [3];
    logic [7:0] pool [20];
    int   ev0;
    bit   m_ev;

    reset = 1'b1; kb_data = 8'h00; kb_valid = 1'b0;
    pa_out = 8'h00; pb_out = 8'hFF; joy_a_n = 5'h1F; joy_b_n = 5'h1F;

    vecs[0]  = '{"reset",        0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 1'b1, 0};
    vecs[1]  = '{"make_a",       1, 8'h1C, 8'h00, 8'h00, 8'hFD, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFB, 1'b1, 1};
    vecs[2]  = '{"break_a",      2, 8'hF0, 8'h1C, 8'h00, 8'hFD, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 1'b1, 1};
    vecs[3]  = '{"space_rev",    1, 8'h29, 8'h00, 8'h00, 8'hFF, 8'hEF, 5'h1F, 5'h1F, 8'h7F, 8'hFF, 1'b1, 1};
    vecs[4]  = '{"joy_a",        0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 5'h1E, 5'h1F, 8'h7E, 8'hFF, 1'b1, 0};
    vecs[5]  = '{"restore_mk",   2, 8'hE0, 8'h7D, 8'h00, 8'hFF, 8'hEF, 5'h1F, 5'h1F, 8'h7F, 8'hFF, 1'b0, 0};
    vecs[6]  = '{"restore_brk",  3, 8'hE0, 8'hF0, 8'h7D, 8'hFF, 8'hEF, 5'h1F, 5'h1F, 8'h7F, 8'hFF, 1'b1, 0};
    vecs[7]  = '{"fake_shift",   2, 8'hE0, 8'h12, 8'h00, 8'hFF, 8'hEF, 5'h1F, 5'h1F, 8'h7F, 8'hFF, 1'b1, 0};
    vecs[8]  = '{"space_brk",    2, 8'hF0, 8'h29, 8'h00, 8'hFF, 8'hEF, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 1'b1, 1};
    vecs[9]  = '{"joy_b",        0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 5'h1F, 5'h0F, 8'hFF, 8'hEF, 1'b1, 0};
    vecs[10] = '{"make_1",       1, 8'h16, 8'h00, 8'h00, 8'h7F, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFE, 1'b1, 1};
    vecs[11] = '{"remake_1",     1, 8'h16, 8'h00, 8'h00, 8'h7F, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFE, 1'b1, 1};
    vecs[12] = '{"brk_released", 2, 8'hF0, 8'h5A, 8'h00, 8'h7F, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFE, 1'b1, 1};
    vecs[13] = '{"make_return",  1, 8'h5A, 8'h00, 8'h00, 8'hFE, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFD, 1'b1, 1};
    vecs[14] = '{"kp_enter",     2, 8'hE0, 8'h5A, 8'h00, 8'h00, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'hFC, 1'b1, 1};
    vecs[15] = '{"rev_multi",    0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFC, 5'h1F, 5'h1F, 8'h7E, 8'hFF, 1'b1, 0};
    vecs[16] = '{"esc",          1, 8'h76, 8'h00, 8'h00, 8'h7F, 8'hFF, 5'h1F, 5'h1F, 8'hFF, 8'h7E, 1'b1, 1};

    // reset value check while reset is still held
    @(negedge clk);
    @(negedge clk);
    chk("rst_pa_in", pa_in, 8'hFF);
    chk("rst_pb_in", pb_in, 8'hFF);
    chk("rst_restore_n", {7'd0, restore_n}, 8'h01);
    chk("rst_key_event", {7'd0, key_event}, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      pa_out = vecs[i].pa_o; pb_out = vecs[i].pb_o;
      joy_a_n = vecs[i].ja;  joy_b_n = vecs[i].jb;
      ev0 = ev_cnt;
      bytes[0] = vecs[i].b0; bytes[1] = vecs[i].b1; bytes[2] = vecs[i].b2;
      for (int j = 0; j < vecs[i].n; j++) send(bytes[j]);
      @(negedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_pa"}, pa_in, vecs[i].e_pa);
      chk({vecs[i].name, "_pb"}, pb_in, vecs[i].e_pb);
      chk({vecs[i].name, "_rst"}, {7'd0, restore_n}, {7'd0, vecs[i].e_rst});
      chk({vecs[i].name, "_ev"}, 8'(ev_cnt - ev0), 8'(vecs[i].e_ev));
    end

    // pause sequence is swallowed whole; only the following space registers
    do_reset();
    pa_out = 8'h7F; pb_out = 8'hFF;
    ev0 = ev_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h29);
    @(negedge clk);
    @(negedge clk);
    chk("pause_pb", pb_in, 8'hEF);
    chk("pause_ev", 8'(ev_cnt - ev0), 8'd1);

    // BAT clears keys and RESTORE, no key_event
    do_reset();
    pa_out = 8'hFD;
    send(8'h1C); send(8'h12); send(8'hE0); send(8'h7D);
    @(negedge clk);
    @(negedge clk);
    chk("bat_pre_pb", pb_in, 8'h7B);
    chk("bat_pre_rst", {7'd0, restore_n}, 8'h00);
    ev0 = ev_cnt;
    send(8'hAA);
    @(negedge clk);
    @(negedge clk);
    chk("bat_pb", pb_in, 8'hFF);
    chk("bat_rst", {7'd0, restore_n}, 8'h01);
    chk("bat_ev", 8'(ev_cnt - ev0), 8'd0);

    // reset after a lone E0: 7D is then unprefixed and misses
    do_reset();
    send(8'hE0);
    do_reset();
    ev0 = ev_cnt;
    send(8'h7D);
    @(negedge clk);
    chk("e0_reset_rst", {7'd0, restore_n}, 8'h01);
    chk("e0_reset_ev", 8'(ev_cnt - ev0), 8'd0);

    // byte arriving during reset is dropped
    @(negedge clk);
    reset = 1'b1;
    pa_out = 8'hFD;
    send(8'h1C);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("valid_in_reset_pb", pb_in, 8'hFF);

    // randomized stimulus against the model
    pool = '{8'h1C, 8'h29, 8'h5A, 8'h12, 8'h59, 8'h76, 8'h16, 8'h1B, 8'h23, 8'h7D,
             8'h74, 8'h77, 8'h00, 8'hAA, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1};
    do_reset();
    m_clear();
    for (int s = 0; s < 300; s++) begin
      pa_out  = 8'($urandom);
      pb_out  = 8'($urandom);
      joy_a_n = 5'($urandom);
      joy_b_n = 5'($urandom);
      m_ev = 1'b0;
      if ($urandom_range(9) < 8) begin
        kb_data  = pool[$urandom_range(19)];
        kb_valid = 1'b1;
        model_byte(kb_data, m_ev);
      end
      @(negedge clk);
      kb_valid = 1'b0;
      chk("rnd_ev", {7'd0, key_event}, {7'd0, m_ev});
      chk("rnd_rst", {7'd0, restore_n}, {7'd0, m_rst_n});
      @(negedge clk);
      chk("rnd_pa", pa_in, m_pa(pb_out, joy_a_n));
      chk("rnd_pb", pb_in, m_pb(pa_out, joy_b_n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
